array_feeder: RTL and testbench
===============================

ARRAY_FEEDER -- requirements
Module: array_feeder

Interface
REQ-001 Parameter data_size, default 8, width of one channel word in bits.
REQ-002 Parameter channels, default 4, number of north-edge columns driven; range 1..16.
REQ-003 Parameter depth, default 8, entry count of the input FIFO; power of two, at least 2.
REQ-004 Parameter skew, default 1, issue delay in cycles between adjacent channels; range 0..4.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port in_valid  input  1  host write request.
REQ-008 Port in_ready  output  1  write accepted this cycle when high with in_valid.
REQ-009 Port in_data  input  channels*data_size  one row; channel c in bits [c*data_size +: data_size].
REQ-010 Port start  input  1  single-cycle request to begin issue.
REQ-011 Port busy  output  1  high while state is RUN or DRAIN.
REQ-012 Port done  output  1  one-cycle pulse when the last word has left the last channel.
REQ-013 Port level  output  $clog2(depth+1)  current FIFO occupancy.
REQ-014 Port fill_o  output  channels  per-channel fill strobe toward array north inputs.
REQ-015 Port data_o  output  channels*data_size  per-channel data, same packing as in_data.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-017 in_ready SHALL be high only in IDLE with level < depth; a write with in_ready low SHALL be dropped with no state change.
REQ-018 An accepted write SHALL push in_data into the FIFO and increment level by 1 at the same edge.
REQ-019 In IDLE, start with level > 0 (value before any same-cycle write) SHALL move to RUN; start with level = 0 SHALL be ignored.
REQ-020 A write and a valid start in the same IDLE cycle SHALL both take effect, and the written row SHALL be issued.
REQ-021 start SHALL be ignored in RUN and DRAIN.
REQ-022 In RUN, one FIFO row SHALL be popped per cycle, in write order.
REQ-023 A row popped in cycle P SHALL appear on channel c (fill_o[c]=1, data_o slice c) in cycle P+1+c*skew, registered.
REQ-024 When fill_o[c] is 0, data_o slice c SHALL be 0.
REQ-025 RUN SHALL go to DRAIN after the cycle popping the last row; DRAIN SHALL last until channel channels-1 has emitted its last word.
REQ-026 done SHALL pulse in the cycle after the last fill_o[channels-1] high cycle, coincident with return to IDLE; busy SHALL be 0 in that cycle.
REQ-027 With start sampled at edge T and N rows, fill_o[c] SHALL be high exactly in cycles T+2+c*skew .. T+1+N+c*skew and done SHALL be high in cycle T+2+N+(channels-1)*skew.
REQ-028 FIFO read and write pointers SHALL wrap modulo depth without loss; level SHALL never exceed depth or go below 0.
REQ-029 With skew = 0, all channels SHALL emit the same row in the same cycle.

Reset
REQ-030 rst high at an edge SHALL clear the FIFO (level=0), all delay stages, and the FSM to IDLE, regardless of state.
REQ-031 After reset: fill_o=0, data_o=0, busy=0, done=0, level=0, in_ready=1.
REQ-032 Reset during RUN or DRAIN SHALL discard in-flight words and SHALL NOT produce done.

Verification (channels=4, depth=8, data_size=8, skew=1 unless stated)
REQ-033 Reset held 2 cycles -> all outputs match REQ-031.
REQ-034 Write rows 0x11/0x22/0x33 (all lanes), start at edge T -> fill_o[0] high T+2..T+4 with data_o slice 0 = 0x11,0x22,0x33; fill_o[3] high T+5..T+7; done at T+8 only.
REQ-035 Nine back-to-back writes -> level=8, in_ready=0 after the 8th; 9th dropped; issue order rows 1..8.
REQ-036 start with level=0 -> busy stays 0, no fill_o, no done.
REQ-037 rst asserted at T+4 in scenario REQ-034 -> from T+5 fill_o=0, level=0, busy=0, no done pulse.
REQ-038 skew=2, one row, start at T -> fill_o[3] high only in cycle T+8; done at T+9.

Source files
------------

// File: rtl/array_feeder.sv
// array_feeder: FIFO-buffered row feeder that issues rows onto skewed north-edge channels.
module array_feeder #(
    parameter int data_size = 8,
    parameter int channels  = 4,
    parameter int depth     = 8,
    parameter int skew      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [channels*data_size-1:0]   in_data,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(depth+1)-1:0]      level,
    output logic [channels-1:0]             fill_o,
    output logic [channels*data_size-1:0]   data_o
);
    localparam int AW   = $clog2(depth);
    localparam int LW   = $clog2(depth + 1);
    localparam int LAST = (channels - 1) * skew;
    localparam int CW   = $clog2(LAST + 2);
    localparam int RW   = channels * data_size;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   mem_q [depth];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            vld0_q;
    logic [RW-1:0]   row0_q;
    logic            push, pop;

    assign in_ready = (state_q == IDLE) && (level_q < LW'(depth));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign level    = level_q;

    // DRAIN waits until the most-delayed channel has emitted the final row
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (start && level_q != '0) state_d = RUN;
            RUN: begin
                if (level_q == LW'(1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(LAST)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            vld0_q  <= 1'b0;
            row0_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            level_q <= level_q + LW'(push) - LW'(pop);
            vld0_q  <= pop;
            row0_q  <= pop ? mem_q[rptr_q] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data;
    end

    // Channel c sees stage 0 delayed by a further c*skew registers; idle slots carry zero data
    for (genvar c = 0; c < channels; c++) begin : g_ch
        if (c * skew == 0) begin : g_direct
            assign fill_o[c]                        = vld0_q;
            assign data_o[c*data_size +: data_size] = row0_q[c*data_size +: data_size];
        end else begin : g_delay
            logic [data_size:0] dly_q [c*skew];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c * skew; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= {vld0_q, row0_q[c*data_size +: data_size]};
                    for (int i = 1; i < c * skew; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign {fill_o[c], data_o[c*data_size +: data_size]} = dly_q[c*skew-1];
        end
    end
endmodule

// File: tb/tb_array_feeder.sv
// tb_array_feeder: scoreboard bench for two feeders (skew 1 and skew 2) sharing one stimulus stream.
module tb_array_feeder;
    localparam int CH    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int RW    = CH * DW;

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
    } ev_t;

    logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, start = 1'b0;
    logic [RW-1:0] in_data = '0;
    logic [1:0] in_ready, busy, done;
    logic [1:0][3:0] level, fill;
    logic [1:0][RW-1:0] data_o;

    ev_t           eq [2][CH][$];
    logic [RW-1:0] mq [2][$];
    int idle_from [2];
    int t_start [2];
    int done_at [2];
    int cyc = 0, checks = 0, errors = 0;
    bit armed = 1'b0;

    array_feeder #(.data_size(DW), .channels(CH), .depth(DEPTH), .skew(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .start(start), .busy(busy[0]), .done(done[0]), .level(level[0]), .fill_o(fill[0]),
        .data_o(data_o[0]));

    array_feeder #(.data_size(DW), .channels(CH), .depth(DEPTH), .skew(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .start(start), .busy(busy[1]), .done(done[1]), .level(level[1]), .fill_o(fill[1]),
        .data_o(data_o[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h want %0h", nm, d, cyc + 1, act, exp);
        end
    endtask

    // Monitor: the observed cycle is the one ending at the next rising edge
    always @(negedge clk) begin
        int obs;
        logic ef;
        logic [DW-1:0] ed;
        if (armed) begin
            obs = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, busy[d], obs > t_start[d] && obs < idle_from[d]);
                chk("done", d, done[d], obs == done_at[d]);
                for (int c = 0; c < CH; c++) begin
                    ef = 1'b0;
                    ed = '0;
                    if (eq[d][c].size() > 0) begin
                        if (eq[d][c][0].cyc == obs) begin
                            ef = 1'b1;
                            ed = eq[d][c][0].dat;
                            void'(eq[d][c].pop_front());
                        end
                    end
                    chk($sformatf("fill%0d", c), d, fill[d][c], ef);
                    chk($sformatf("data%0d", c), d, data_o[d][c*DW +: DW], ed);
                end
            end
        end
    end

    // One input cycle: status check for the current cycle, then model update for the next edge
    task automatic drive(input bit v, input logic [RW-1:0] row, input bit st, input bit r);
        int e, n, sk;
        bit idle, sok;
        logic [RW-1:0] rr;
        @(negedge clk);
        #1;
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                if (cyc + 1 >= idle_from[d]) begin
                    chk("level", d, level[d], mq[d].size());
                    chk("in_ready", d, in_ready[d], mq[d].size() < DEPTH);
                end
            end
        end
        e = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            sk = (d == 0) ? 1 : 2;
            if (r) begin
                mq[d].delete();
                for (int c = 0; c < CH; c++) eq[d][c].delete();
                done_at[d]   = -1;
                t_start[d]   = e;
                idle_from[d] = e + 1;
            end else begin
                idle = (e >= idle_from[d]);
                sok  = st && idle && mq[d].size() > 0;
                if (v && idle && mq[d].size() < DEPTH) mq[d].push_back(row);
                if (sok) begin
                    n = mq[d].size();
                    for (int k = 0; k < n; k++) begin
                        rr = mq[d].pop_front();
                        for (int c = 0; c < CH; c++)
                            eq[d][c].push_back('{e + 2 + k + c * sk, rr[c*DW +: DW]});
                    end
                    done_at[d]   = e + 2 + n + (CH - 1) * sk;
                    t_start[d]   = e;
                    idle_from[d] = done_at[d];
                end
            end
        end
        in_valid = v;
        in_data  = row;
        start    = st;
        rst      = r;
    endtask

    task automatic idle_cycle();
        drive(1'b0, RW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((cyc + 1 < idle_from[0] || cyc + 1 < idle_from[1]) && g < 300) begin
            idle_cycle();
            g++;
        end
        idle_cycle();
    endtask

    initial begin
        logic [7:0] b;
        int nw, mode, tot;
        repeat (2) drive(1'b0, '0, 1'b0, 1'b1);
        armed = 1'b1;
        // start on an empty FIFO is ignored
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) idle_cycle();
        // three uniform rows then start
        drive(1'b1, {CH{8'h11}}, 1'b0, 1'b0);
        drive(1'b1, {CH{8'h22}}, 1'b0, 1'b0);
        drive(1'b1, {CH{8'h33}}, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        wait_idle();
        // same run, reset four edges after start
        drive(1'b1, {CH{8'h11}}, 1'b0, 1'b0);
        drive(1'b1, {CH{8'h22}}, 1'b0, 1'b0);
        drive(1'b1, {CH{8'h33}}, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) idle_cycle();
        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (3) idle_cycle();
        // single row
        drive(1'b1, RW'($urandom), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        wait_idle();
        // nine writes into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) begin
            b = 8'(i);
            drive(1'b1, {CH{b}}, 1'b0, 1'b0);
        end
        idle_cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        wait_idle();
        // write and start in the same cycle
        drive(1'b1, RW'($urandom), 1'b0, 1'b0);
        drive(1'b1, RW'($urandom), 1'b1, 1'b0);
        wait_idle();
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, 9);
            for (int i = 0; i < nw; i++) begin
                drive(1'b1, RW'($urandom), 1'b0, 1'b0);
                if ($urandom_range(0, 3) == 0) idle_cycle();
            end
            mode = $urandom_range(0, 3);
            if (mode == 0) drive(1'b0, RW'($urandom), 1'b1, 1'b0);
            else if (mode == 1) drive(1'b1, RW'($urandom), 1'b1, 1'b0);
            else if (mode == 2) begin
                drive(1'b0, RW'($urandom), 1'b1, 1'b0);
                repeat (4) drive(1'($urandom), RW'($urandom), 1'($urandom), 1'b0);
            end else begin
                drive(1'b0, RW'($urandom), 1'b1, 1'b0);
                repeat ($urandom_range(0, 6)) idle_cycle();
                drive(1'b0, '0, 1'b0, 1'b1);
            end
            wait_idle();
        end
        repeat (5) idle_cycle();
        tot = 0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) tot += eq[d][c].size();
        chk("leftover", 0, tot, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
